// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: datapath <-> multi-cycle controller handshake and select bundle
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       illegal;
  modport master (
    input  op, funct, zero, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src, state, illegal
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src, state, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset controller sequencing IF/ID/EX/MEM/WB
module mc_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic        clk,
  input logic        rst,
  mc_ctrl_if.master  bus
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EX_R = 4'd2, S_EX_SH = 4'd3, S_EX_I = 4'd4,
    S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7, S_MEM_WR = 4'd8,
    S_R_WB = 4'd9, S_I_WB = 4'd10, S_BR = 4'd11, S_JMP = 4'd12, S_HALT = 4'd13
  } state_t;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010, OR = 4'b0011,
                         SLT = 4'b0100, SLL = 4'b0101, SRL = 4'b0110;
  state_t st, nxt, id_nxt;
  logic [5:0] op_q, funct_q;
  logic illegal_q, sh_ok, r_ok;
  logic pcw, irw, memw, regw;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= state_t'(RESET_STATE);
      op_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      st <= nxt;
      if (st == S_ID) begin
        op_q    <= bus.op;
        funct_q <= bus.funct;
      end
      if (nxt == S_HALT) illegal_q <= 1'b1;
    end
  end
  // ID decodes the live IR; later states only look at the latched copies
  always_comb begin
    sh_ok  = bus.op == 6'b000000 && (bus.funct == 6'b000000 || bus.funct == 6'b000010);
    r_ok   = bus.op == 6'b000000 && (bus.funct == 6'b100000 || bus.funct == 6'b100010 ||
             bus.funct == 6'b100100 || bus.funct == 6'b100101 || bus.funct == 6'b101010);
    id_nxt = sh_ok ? S_EX_SH :
             r_ok ? S_EX_R :
             bus.op == 6'b001000 ? S_EX_I :
             (bus.op == 6'b100011 || bus.op == 6'b101011) ? S_MEM_ADDR :
             bus.op == 6'b000100 ? S_BR :
             bus.op == 6'b000010 ? S_JMP : S_HALT;
  end
  always_comb begin
    nxt            = S_IF;
    pcw            = 1'b0;
    irw            = 1'b0;
    memw           = 1'b0;
    regw           = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_ctrl   = ADD;
    bus.pc_src     = 2'b00;
    case (st)
      S_IF: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        pcw           = bus.mem_ready;
        irw           = bus.mem_ready;
        nxt           = bus.mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        bus.alu_src_b = 2'b11;
        nxt           = id_nxt;
      end
      S_EX_R: begin
        bus.alu_ctrl = funct_q == 6'b100010 ? SUB :
                       funct_q == 6'b100100 ? AND :
                       funct_q == 6'b100101 ? OR :
                       funct_q == 6'b101010 ? SLT : ADD;
        nxt          = S_R_WB;
      end
      S_EX_SH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = funct_q == 6'b000000 ? SLL : SRL;
        nxt           = S_R_WB;
      end
      S_EX_I: begin
        bus.alu_src_b = 2'b10;
        nxt           = S_I_WB;
      end
      S_MEM_ADDR: begin
        bus.alu_src_b = 2'b10;
        nxt           = op_q == 6'b100011 ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        nxt          = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        regw           = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        memw       = 1'b1;
        bus.i_or_d = 1'b1;
        nxt        = bus.mem_ready ? S_IF : S_MEM_WR;
      end
      S_R_WB: begin
        regw        = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_I_WB: regw = 1'b1;
      S_BR: begin
        bus.alu_ctrl = SUB;
        bus.pc_src   = 2'b01;
        pcw          = bus.zero;
      end
      S_JMP: begin
        bus.pc_src = 2'b10;
        pcw        = 1'b1;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end
  // state is already IF during reset; this only keeps the IF strobes quiet
  assign bus.pc_write  = pcw & ~rst;
  assign bus.ir_write  = irw & ~rst;
  assign bus.mem_write = memw & ~rst;
  assign bus.reg_write = regw & ~rst;
  assign bus.state     = st;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard-driven directed test of the multi-cycle controller
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  string name;
  mc_ctrl_if bus ();
  mc_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic mr;
    logic z;
    logic [21:0] e;
  } ent_t;
  ent_t q[$];
  logic [21:0] obs;
  assign obs = {bus.state, bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_ctrl, bus.pc_src, bus.illegal};
  function automatic logic [21:0] v(input logic [3:0] s, input logic [7:0] str, input logic a,
                                    input logic [1:0] b, input logic [3:0] alu,
                                    input logic [1:0] ps, input logic il);
    return {s, str, a, b, alu, ps, il};
  endfunction
  task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic push(input logic mr, input logic z, input logic [3:0] s, input logic [7:0] str,
                      input logic a, input logic [1:0] b, input logic [3:0] alu,
                      input logic [1:0] ps, input logic il);
    q.push_back('{mr, z, v(s, str, a, b, alu, ps, il)});
  endtask
  task automatic p_if(input logic mr);
    push(mr, 0, 4'd0, mr ? 8'b11010000 : 8'b00010000, 0, 2'b01, 4'b0000, 2'b00, 0);
  endtask
  task automatic p_id(input logic il);
    push(1, 0, 4'd1, 8'b0, 0, 2'b11, 4'b0000, 2'b00, il);
  endtask
  task automatic run();
    int k = 0;
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      bus.mem_ready = e.mr;
      bus.zero = e.z;
      @(negedge clk);
      chk($sformatf("%s c%0d", name, k), obs, e.e);
      k++;
      @(posedge clk);
      #1;
    end
  endtask
  logic [5:0] fr[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0] ar[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
  logic [21:0] rst_vec;
  initial begin
    rst_vec = v(4'd0, 8'b00010000, 0, 2'b01, 4'b0000, 2'b00, 0);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.op = 6'b0;
    bus.funct = 6'b0;
    @(negedge clk);
    chk("reset_hold", obs, rst_vec);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      name = $sformatf("rtype%0d", i);
      bus.op = 6'b000000;
      bus.funct = fr[i];
      p_if(1); p_id(0);
      push(1, 0, 4'd2, 8'b0, 0, 2'b00, ar[i], 2'b00, 0);
      push(1, 0, 4'd9, 8'b00000110, 0, 2'b00, 4'b0000, 2'b00, 0);
      run();
    end
    name = "sll";
    bus.funct = 6'b000000;
    p_if(1); p_id(0);
    push(1, 0, 4'd3, 8'b0, 1, 2'b00, 4'b0101, 2'b00, 0);
    push(1, 0, 4'd9, 8'b00000110, 0, 2'b00, 4'b0000, 2'b00, 0);
    run();
    name = "srl";
    bus.funct = 6'b000010;
    p_if(1); p_id(0);
    push(1, 0, 4'd3, 8'b0, 1, 2'b00, 4'b0110, 2'b00, 0);
    push(1, 0, 4'd9, 8'b00000110, 0, 2'b00, 4'b0000, 2'b00, 0);
    run();
    name = "addi";
    bus.op = 6'b001000;
    bus.funct = 6'b111111;
    p_if(1); p_id(0);
    push(1, 0, 4'd4, 8'b0, 0, 2'b10, 4'b0000, 2'b00, 0);
    push(1, 0, 4'd10, 8'b00000100, 0, 2'b00, 4'b0000, 2'b00, 0);
    run();
    name = "lw_wait";
    bus.op = 6'b100011;
    p_if(1); p_id(0);
    push(1, 0, 4'd5, 8'b0, 0, 2'b10, 4'b0000, 2'b00, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 4'd6, 8'b00110000, 0, 2'b00, 4'b0000, 2'b00, 0);
    push(1, 0, 4'd6, 8'b00110000, 0, 2'b00, 4'b0000, 2'b00, 0);
    push(1, 0, 4'd7, 8'b00000101, 0, 2'b00, 4'b0000, 2'b00, 0);
    run();
    name = "beq_taken";
    bus.op = 6'b000100;
    p_if(1); p_id(0);
    push(1, 1, 4'd11, 8'b10000000, 0, 2'b00, 4'b0001, 2'b01, 0);
    run();
    name = "beq_not";
    p_if(1); p_id(0);
    push(1, 0, 4'd11, 8'b00000000, 0, 2'b00, 4'b0001, 2'b01, 0);
    run();
    name = "j_fetchwait";
    bus.op = 6'b000010;
    p_if(0); p_if(1); p_id(0);
    push(1, 0, 4'd12, 8'b10000000, 0, 2'b00, 4'b0000, 2'b10, 0);
    run();
    name = "sw";
    bus.op = 6'b101011;
    p_if(1); p_id(0);
    push(1, 0, 4'd5, 8'b0, 0, 2'b10, 4'b0000, 2'b00, 0);
    push(0, 0, 4'd8, 8'b00101000, 0, 2'b00, 4'b0000, 2'b00, 0);
    push(1, 0, 4'd8, 8'b00101000, 0, 2'b00, 4'b0000, 2'b00, 0);
    p_if(1);
    run();
    name = "sw_rst";
    bus.op = 6'b101011;
    p_id(0);
    push(1, 0, 4'd5, 8'b0, 0, 2'b10, 4'b0000, 2'b00, 0);
    push(0, 0, 4'd8, 8'b00101000, 0, 2'b00, 4'b0000, 2'b00, 0);
    run();
    bus.mem_ready = 1'b0;
    #2;
    chk("sw_wait_pre_rst", obs, v(4'd8, 8'b00101000, 0, 2'b00, 4'b0000, 2'b00, 0));
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("sw_rst_async", obs, rst_vec);
    @(posedge clk);
    #1;
    chk("sw_rst_held", obs, rst_vec);
    rst = 1'b0;
    name = "illegal";
    bus.op = 6'b111111;
    p_if(1); p_id(0);
    for (int i = 0; i < 20; i++) push(1, 1, 4'd13, 8'b0, 0, 2'b00, 4'b0000, 2'b00, 1);
    run();
    #2 rst = 1'b1;
    #1;
    chk("halt_rst_async", obs, rst_vec);
    @(posedge clk);
    #1 rst = 1'b0;
    name = "after_halt_add";
    bus.op = 6'b000000;
    bus.funct = 6'b100000;
    p_if(1); p_id(0);
    push(1, 0, 4'd2, 8'b0, 0, 2'b00, 4'b0000, 2'b00, 0);
    push(1, 0, 4'd9, 8'b00000110, 0, 2'b00, 4'b0000, 2'b00, 0);
    p_if(1);
    run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
